// File: rtl/hamming_frame_ctrl.sv
// Sequencer for the 15/11 Hamming encode path.
// Paces 11 captured bits into one load and 15 coded bits out.
module hamming_frame_ctrl #(
   parameter int DATA_W = 11,
   parameter int CODE_W = 15,
   parameter int CNT_W  = 4,
   parameter int FCNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              cap_shift,
   output logic              enc_load,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              tx_shift,
   output logic              frame_done,
   output logic              busy,
   output logic [FCNT_W-1:0] frames_sent
);

   typedef enum logic {CAP_FILL, CAP_HOLD} cap_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_t;

   localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(CODE_W - 1);

   cap_t             cap_state;
   tx_t              tx_state;
   logic [CNT_W-1:0] cap_cnt;
   logic [CNT_W-1:0] tx_cnt;
   logic             word_pending;
   logic             done_q;

   // Handshake strobes; flush masks every accept, load and transfer.
   always_comb begin
      in_ready   = (cap_state == CAP_FILL);
      out_valid  = (tx_state == TX_SEND);
      cap_shift  = in_valid & in_ready & ~flush;
      tx_shift   = out_valid & out_ready & ~flush;
      enc_load   = word_pending & (tx_state == TX_IDLE) & ~flush;
      frame_done = done_q & ~flush;
      busy       = (cap_cnt != '0) | word_pending | (tx_state == TX_SEND);
   end

   // Capture FSM: count accepted bits, then hold the word until loaded.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_state    <= CAP_FILL;
         cap_cnt      <= '0;
         word_pending <= 1'b0;
      end else if (flush) begin
         cap_state    <= CAP_FILL;
         cap_cnt      <= '0;
         word_pending <= 1'b0;
      end else begin
         unique case (1'b1)
            enc_load: begin
               word_pending <= 1'b0;
               cap_state    <= CAP_FILL;
            end
            cap_shift: begin
               if (cap_cnt == CAP_LAST) begin
                  cap_cnt      <= '0;
                  word_pending <= 1'b1;
                  cap_state    <= CAP_HOLD;
               end else begin
                  cap_cnt <= cap_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // TX FSM: start on load, count 15 transfers, then go idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
      end else if (flush) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
      end else begin
         unique case (1'b1)
            enc_load: begin
               tx_state <= TX_SEND;
               tx_cnt   <= '0;
            end
            tx_shift: begin
               if (tx_cnt == TX_LAST) begin
                  tx_state <= TX_IDLE;
                  tx_cnt   <= '0;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame completion pulse and wrapping frame counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q      <= 1'b0;
         frames_sent <= '0;
      end else if (flush) begin
         done_q <= 1'b0;
      end else begin
         done_q <= tx_shift & (tx_cnt == TX_LAST);
         if (tx_shift && tx_cnt == TX_LAST)
            frames_sent <= frames_sent + 1'b1;
      end
   end

endmodule

// File: doc/hamming_frame_ctrl.md
Name: hamming_frame_ctrl

Overview:
- Single-clock sequencer for the 15/11 Hamming encode path: input shift register, combinational encoder, output shift register.
- Counts 11 accepted serial data bits, issues a one-cycle parallel-load strobe to the output register, then paces 15 coded bits out under a valid/ready handshake.
- Capture of the next frame overlaps transmission of the current one, with backpressure on the input when a captured word cannot yet be loaded.

Parameters:
- DATA_W, 11, data bits per frame (input shift register width).
- CODE_W, 15, coded bits per frame (output shift register width).
- CNT_W, 4, width of the capture and transmit bit counters; 2^CNT_W must be at least CODE_W.
- FCNT_W, 8, width of the transmitted-frame counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort: clears all counters and returns both FSMs to their idle/fill states.
- in_valid  in  1  serial source presents a data bit.
- in_ready  out  1  controller accepts a data bit this cycle.
- cap_shift  out  1  shift enable to the input register; equals in_valid & in_ready.
- enc_load  out  1  one-cycle parallel-load strobe to the output register.
- out_valid  out  1  output register holds a coded bit for the sink.
- out_ready  in  1  sink accepts the coded bit.
- tx_shift  out  1  shift enable to the output register; equals out_valid & out_ready.
- frame_done  out  1  one-cycle pulse, registered, the cycle after the 15th coded bit transfers.
- busy  out  1  high when cap_cnt != 0, word_pending = 1, or TX_SEND.
- frames_sent  out  FCNT_W  count of completed frames; wraps to 0 after 2^FCNT_W-1.

Behaviour:
- Reset (reset=0, asynchronous): cap_cnt=0, tx_cnt=0, word_pending=0, capture FSM in CAP_FILL, TX FSM in TX_IDLE, frame_done=0, frames_sent=0.
  - Combinational outputs during reset: in_ready=1, out_valid=0, enc_load=0.
- Capture FSM, states CAP_FILL and CAP_HOLD:
  - CAP_FILL: in_ready=1. Each accepted bit increments cap_cnt.
  - An accept with cap_cnt=DATA_W-1 sets cap_cnt=0 and word_pending=1, then moves to CAP_HOLD.
  - CAP_HOLD: in_ready=0; in_valid is ignored.
- Load:
  - enc_load = word_pending & (TX FSM in TX_IDLE), combinational.
  - On the enc_load cycle: word_pending clears, capture FSM moves to CAP_FILL, TX FSM moves to TX_SEND, tx_cnt=0.
- TX FSM, states TX_IDLE and TX_SEND:
  - TX_SEND: out_valid=1. Each transfer increments tx_cnt.
  - A transfer with tx_cnt=CODE_W-1 returns the FSM to TX_IDLE and sets tx_cnt=0. On the next cycle frame_done pulses and frames_sent increments.
  - out_valid stays high while out_ready is low; tx_cnt is held.
- Latency and throughput:
  - The 11th accepted input bit is followed by enc_load on the next cycle, provided TX is idle.
  - The first coded bit is valid the cycle after enc_load.
  - Back-to-back frames have exactly one idle cycle between the last transfer and the next enc_load. Sustained throughput is 15 bits per 16 cycles with out_ready tied high.
- Overlap and backpressure:
  - The next frame is captured during TX_SEND.
  - If capture completes while TX is busy, in_ready stays 0 until enc_load.
- Simultaneous events:
  - flush has priority over every accept, load and transfer in the same cycle. In that cycle cap_shift, tx_shift and enc_load are forced to 0.
  - frames_sent is not cleared by flush.
  - frame_done from a completed frame is suppressed if flush is asserted in the pulse cycle.
- Reset mid-frame: partial frames are discarded; no frame_done is generated.
- cap_shift and tx_shift are never high while in_ready or out_valid, respectively, is low.

Test Plan:
- Single frame, 11 bits with in_valid=1 continuous and out_ready=1 -> enc_load at cycle 12, out_valid cycles 13-27, 15 tx_shift pulses, frame_done at cycle 28, frames_sent=1.
- Three frames with in_valid and out_ready held high -> one bubble cycle between frames; frames_sent=3; in_ready drops to 0 between each 11th accept and the next enc_load.
- out_ready toggling 1,0,1,0 -> exactly 15 tx_shift pulses; frame completes in 29 transfer-window cycles; tx_cnt holds while out_ready=0.
- Second frame captured while out_ready=0 -> in_ready=0 after 11 accepts; enc_load fires the cycle after TX returns to idle; no input bits lost or extra.
- flush asserted after 6 input bits and again at tx_cnt=7 -> cap_cnt=0 and tx_cnt=0, TX_IDLE, no frame_done; frames_sent unchanged; next frame requires a full 11 bits.
- reset pulled low for 1 cycle mid-transmission -> all outputs at reset values immediately (asynchronous); frames_sent=0.
- FCNT_W=2 run of 5 frames -> frames_sent sequence 1,2,3,0,1.
